// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel framing controller: hunts for SYNC, slices locked stream into
// BIT-wide words, and hands each word out through a one-entry valid/ready register.
module s2p_frame_ctrl #(
   parameter int unsigned    BIT      = 10,
   parameter logic [BIT-1:0] SYNC     = 10'h34E,
   parameter int unsigned    WORDS    = 4,
   parameter int unsigned    MISS_MAX = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           dext,
   output logic [BIT-1:0] dout,
   output logic           dout_valid,
   input  logic           dout_ready,
   output logic           dout_sof,
   output logic           locked,
   output logic           overflow,
   input  logic           clr_ovf
);

   localparam int BW = (BIT > 1) ? $clog2(BIT) : 1;
   localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int MW = $clog2(MISS_MAX + 1);
   localparam logic [BW-1:0] BLAST = BW'(BIT - 1);
   localparam logic [WW-1:0] WLAST = WW'(WORDS - 1);
   localparam logic [MW-1:0] MLAST = MW'(MISS_MAX - 1);

   typedef enum logic [1:0] {S_HUNT, S_DATA, S_CHECK} state_t;

   state_t         state_q, state_d;
   logic [BIT-1:0] sr_q, sr_d, nxt;
   logic [BW-1:0]  bcnt_q, bcnt_d;
   logic [WW-1:0]  wcnt_q, wcnt_d;
   logic [MW-1:0]  miss_q, miss_d;
   logic           locked_q, locked_d;
   logic [BIT-1:0] dout_q, dout_d;
   logic           valid_q, valid_d;
   logic           sof_q, sof_d;
   logic           ovf_q, ovf_d;
   logic           push, push_sof, pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_HUNT;
         sr_q     <= '0;
         bcnt_q   <= '0;
         wcnt_q   <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         sof_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         bcnt_q   <= bcnt_d;
         wcnt_q   <= wcnt_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         sof_q    <= sof_d;
         ovf_q    <= ovf_d;
      end
   end

   // Framing: bcnt walks bit positions in both the data and sync slots.
   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      bcnt_d   = bcnt_q;
      wcnt_d   = wcnt_q;
      miss_d   = miss_q;
      locked_d = locked_q;
      push     = 1'b0;
      push_sof = 1'b0;
      nxt      = {sr_q[BIT-2:0], dext};
      if (en) begin
         sr_d = nxt;
         case (state_q)
            S_HUNT: begin
               if (nxt == SYNC) begin
                  state_d  = S_DATA;
                  bcnt_d   = '0;
                  wcnt_d   = '0;
                  miss_d   = '0;
                  locked_d = 1'b1;
               end
            end
            S_DATA: begin
               if (bcnt_q == BLAST) begin
                  bcnt_d   = '0;
                  push     = 1'b1;
                  push_sof = (wcnt_q == '0);
                  if (wcnt_q == WLAST) begin
                     wcnt_d  = '0;
                     state_d = S_CHECK;
                  end else begin
                     wcnt_d = wcnt_q + 1'b1;
                  end
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            S_CHECK: begin
               if (bcnt_q == BLAST) begin
                  bcnt_d = '0;
                  if (nxt == SYNC) begin
                     miss_d  = '0;
                     state_d = S_DATA;
                  end else if (miss_q == MLAST) begin
                     miss_d   = '0;
                     state_d  = S_HUNT;
                     locked_d = 1'b0;
                  end else begin
                     // flywheel: a tolerated bad sync still realigns to the next frame
                     miss_d  = miss_q + 1'b1;
                     state_d = S_DATA;
                  end
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            default: state_d = S_HUNT;
         endcase
      end
   end

   // Output register: a push lands if the slot is free or being popped this edge.
   always_comb begin
      dout_d  = dout_q;
      valid_d = valid_q;
      sof_d   = sof_q;
      ovf_d   = ovf_q;
      pop     = valid_q && dout_ready;
      if (clr_ovf) ovf_d = 1'b0;
      if (push) begin
         if (!valid_q || pop) begin
            dout_d  = nxt;
            sof_d   = push_sof;
            valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign dout_sof   = sof_q;
   assign locked     = locked_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: a frame-position model is compared on every
// cycle, and literal expectations pin key points of each scenario.
module tb_s2p_frame_ctrl;
   localparam int         BIT      = 10;
   localparam logic [9:0] SYNC     = 10'h34E;
   localparam int         WORDS    = 4;
   localparam int         MISS_MAX = 2;
   localparam int         FLEN     = (WORDS + 1) * BIT;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1, dext = 1'b0;
   logic       dout_ready = 1'b1, clr_ovf = 1'b0;
   logic [9:0] dout;
   logic       dout_valid, dout_sof, locked, overflow;

   int nvec = 0, nerr = 0;

   s2p_frame_ctrl #(.BIT(BIT), .SYNC(SYNC), .WORDS(WORDS), .MISS_MAX(MISS_MAX)) dut (
      .clk(clk), .rst(rst), .en(en), .dext(dext), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_sof(dout_sof), .locked(locked), .overflow(overflow),
      .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: mpos is the bit position inside the locked frame (words then sync slot), -1 when hunting.
   int         mpos = -1, mmiss = 0;
   logic [9:0] mhist = '0, m_dout = '0, mp_w = '0;
   logic       m_valid = 1'b0, m_sof = 1'b0, m_lock = 1'b0, m_ovf = 1'b0;
   logic       mp_push = 1'b0, mp_sof = 1'b0, m_pop = 1'b0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         mpos = -1; mmiss = 0; mhist = '0; m_dout = '0;
         m_valid = 1'b0; m_sof = 1'b0; m_lock = 1'b0; m_ovf = 1'b0;
      end else begin
         m_pop   = m_valid && dout_ready;
         mp_push = 1'b0;
         if (en) begin
            mhist = {mhist[8:0], dext};
            if (mpos < 0) begin
               if (mhist == SYNC) begin mpos = 0; mmiss = 0; m_lock = 1'b1; end
            end else begin
               if (mpos < WORDS * BIT && mpos % BIT == BIT - 1) begin
                  mp_push = 1'b1; mp_w = mhist; mp_sof = (mpos == BIT - 1);
               end
               mpos++;
               if (mpos == FLEN) begin
                  mpos = 0;
                  if (mhist == SYNC) mmiss = 0;
                  else begin
                     mmiss++;
                     if (mmiss == MISS_MAX) begin mmiss = 0; mpos = -1; m_lock = 1'b0; end
                  end
               end
            end
         end
         if (clr_ovf) m_ovf = 1'b0;
         if (mp_push) begin
            if (!m_valid || m_pop) begin m_dout = mp_w; m_sof = mp_sof; m_valid = 1'b1; end
            else m_ovf = 1'b1;
         end else if (m_pop) m_valid = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("model_valid", dout_valid, m_valid);
      chk("model_dout", dout, m_dout);
      chk("model_sof", dout_sof, m_sof);
      chk("model_locked", locked, m_lock);
      chk("model_overflow", overflow, m_ovf);
   end

   logic [9:0] tx_hist = '0;
   logic [9:0] sync_v  = SYNC;
   logic [9:0] fw [4]  = '{10'h001, 10'h3FF, 10'h155, 10'h2AA};

   task automatic step(input logic b);
      dext = b;
      @(posedge clk); #2;
      if (en) tx_hist = {tx_hist[8:0], b};
   endtask

   task automatic send_bits(input logic [9:0] w, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) step(w[i]);
   endtask

   task automatic send(input logic [9:0] w);
      send_bits(w, 9, 0);
   endtask

   task automatic frame_chk(input bit emit);
      for (int i = 0; i < WORDS; i++) begin
         send(fw[i]);
         if (emit) begin
            chk("frame_valid", dout_valid, 1);
            chk("frame_dout", dout, fw[i]);
            chk("frame_sof", dout_sof, (i == 0));
         end else begin
            chk("unlocked_no_word", dout_valid, 0);
         end
      end
   endtask

   // Random bits that can neither complete SYNC nor end on SYNC's first nine bits.
   task automatic rand_bits(input int n);
      logic       b;
      logic [9:0] cand;
      for (int k = 0; k < n; k++) begin
         b    = 1'($urandom_range(0, 1));
         cand = {tx_hist[8:0], b};
         if (cand == sync_v || cand[8:0] == sync_v[9:1]) b = ~b;
         step(b);
      end
   endtask

   initial begin
      @(posedge clk); #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", dout_valid, 0);
      chk("rst_locked", locked, 0);
      chk("rst_overflow", overflow, 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // lock and stream one frame with ready held high
      send(SYNC);
      chk("lock_after_sync", locked, 1);
      frame_chk(1);
      step(1'b1);
      chk("popped", dout_valid, 0);
      send_bits(10'h34F, 8, 0);
      chk("flywheel_hold", locked, 1);
      frame_chk(1);
      send(10'h34F);
      chk("lock_lost", locked, 0);
      frame_chk(0);

      // relock after noise
      rand_bits(40);
      chk("noise_no_lock", locked, 0);
      for (int i = 0; i < 4; i++) step(1'b0);
      send(SYNC);
      chk("relock", locked, 1);
      frame_chk(1);

      // backpressure, drops and overflow clearing
      send(SYNC);
      dout_ready = 1'b0;
      send(fw[0]);
      chk("bp_w0_valid", dout_valid, 1);
      chk("bp_w0_ovf", overflow, 0);
      send(fw[1]);
      chk("bp_ovf_set", overflow, 1);
      chk("bp_dout_held", dout, 10'h001);
      send_bits(fw[2], 9, 1);
      clr_ovf = 1'b1;
      step(fw[2][0]);
      clr_ovf = 1'b0;
      chk("clr_vs_drop", overflow, 1);
      send(fw[3]);
      dout_ready = 1'b1;
      step(sync_v[9]);
      dout_ready = 1'b0;
      chk("bp_pop", dout_valid, 0);
      clr_ovf = 1'b1;
      step(sync_v[8]);
      clr_ovf = 1'b0;
      chk("ovf_cleared", overflow, 0);
      send_bits(SYNC, 7, 0);

      // ready rises on the edge a word completes: push and pop together
      send(fw[0]);
      chk("sim_w0", dout, 10'h001);
      send_bits(fw[1], 9, 1);
      dout_ready = 1'b1;
      step(fw[1][0]);
      chk("sim_dout", dout, 10'h3FF);
      chk("sim_valid", dout_valid, 1);
      chk("sim_no_ovf", overflow, 0);
      send(fw[2]);
      send(fw[3]);

      // enable gap in the middle of a word
      send(SYNC);
      send(fw[0]);
      send(fw[1]);
      send_bits(fw[2], 9, 5);
      en = 1'b0;
      for (int i = 0; i < 5; i++) step(i[0]);
      en = 1'b1;
      send_bits(fw[2], 4, 0);
      chk("en_gap_word", dout, 10'h155);
      chk("en_gap_valid", dout_valid, 1);

      // asynchronous reset mid-frame
      send_bits(fw[3], 9, 5);
      rst = 1'b1;
      #1;
      chk("arst_dout", dout, 0);
      chk("arst_valid", dout_valid, 0);
      chk("arst_sof", dout_sof, 0);
      chk("arst_locked", locked, 0);
      chk("arst_ovf", overflow, 0);
      #1;
      rst = 1'b0;
      tx_hist = '0;
      send(SYNC);
      chk("post_rst_lock", locked, 1);
      frame_chk(1);
      step(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
